// File: rtl/gpio_sd_clk_gen.sv
// Divided SD/SPI clock generator driven by the 2-bit PIO control word, with rise/fall strobes.
// Optional rising-edge counter enabled by defining GPIO_SD_CLK_EDGE_CNT_EN.
module gpio_sd_clk_gen #(
  parameter int SLOW_DIV = 63,
  parameter int FAST_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ctrl_in,
  output logic        sd_clk,
  output logic        rise_stb,
  output logic        fall_stb,
  output logic        running,
  output logic        cur_fast,
  output logic [15:0] edge_count
);

  // state | meaning
  // IDLE  | clock parked low, waiting for enable
  // HIGH  | sd_clk high, counting down the high half-period
  // LOW   | sd_clk low, counting down the low half-period
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam int SLOW_EFF = (SLOW_DIV < 1) ? 1 : SLOW_DIV;
  localparam int FAST_EFF = (FAST_DIV < 1) ? 1 : FAST_DIV;
  localparam logic [DIV_W-1:0] SLOW_M1 = DIV_W'(SLOW_EFF - 1);
  localparam logic [DIV_W-1:0] FAST_M1 = DIV_W'(FAST_EFF - 1);

  state_t           state_q;
  logic [1:0]       ctrl_q;
  logic [DIV_W-1:0] cnt_q;
  logic             sd_clk_q;
  logic             rise_stb_q;
  logic             fall_stb_q;
  logic             running_q;
  logic             cur_fast_q;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] new_div_m1;
`ifdef GPIO_SD_CLK_EDGE_CNT_EN
  logic [15:0]      edge_cnt_q;
`endif

  // The low phase reuses the speed latched at the preceding rise, so a phase is never shortened.
  assign div_m1     = cur_fast_q ? FAST_M1 : SLOW_M1;
  assign new_div_m1 = ctrl_q[1]  ? FAST_M1 : SLOW_M1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ctrl_q     <= 2'b00;
      cnt_q      <= '0;
      sd_clk_q   <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      running_q  <= 1'b0;
      cur_fast_q <= 1'b0;
`ifdef GPIO_SD_CLK_EDGE_CNT_EN
      edge_cnt_q <= 16'd0;
`endif
    end else begin
      ctrl_q     <= ctrl_in;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrl_q[0]) begin
            state_q    <= HIGH;
            cur_fast_q <= ctrl_q[1];
            sd_clk_q   <= 1'b1;
            rise_stb_q <= 1'b1;
            running_q  <= 1'b1;
            cnt_q      <= new_div_m1;
`ifdef GPIO_SD_CLK_EDGE_CNT_EN
            edge_cnt_q <= 16'd1;
`endif
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_q    <= LOW;
            sd_clk_q   <= 1'b0;
            fall_stb_q <= 1'b1;
            cnt_q      <= div_m1;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (ctrl_q[0]) begin
              state_q    <= HIGH;
              cur_fast_q <= ctrl_q[1];
              sd_clk_q   <= 1'b1;
              rise_stb_q <= 1'b1;
              cnt_q      <= new_div_m1;
`ifdef GPIO_SD_CLK_EDGE_CNT_EN
              edge_cnt_q <= edge_cnt_q + 16'd1;
`endif
            end else begin
              state_q   <= IDLE;
              running_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_clk   = sd_clk_q;
  assign rise_stb = rise_stb_q;
  assign fall_stb = fall_stb_q;
  assign running  = running_q;
  assign cur_fast = cur_fast_q;
`ifdef GPIO_SD_CLK_EDGE_CNT_EN
  assign edge_count = edge_cnt_q;
`else
  assign edge_count = 16'd0;
`endif

endmodule

// File: tb/tb_gpio_sd_clk_gen.sv
// Bench for gpio_sd_clk_gen: phase-length reference model, directed waveform checks, random control traffic.
module tb_gpio_sd_clk_gen;

  localparam int SD = 63;
  localparam int FD = 1;
`ifdef GPIO_SD_CLK_EDGE_CNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ctrl_in = 2'b00;
  logic        sd_clk, rise_stb, fall_stb, running, cur_fast;
  logic [15:0] edge_count;

  int n_vec = 0;
  int n_err = 0;

  gpio_sd_clk_gen dut (
    .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in),
    .sd_clk(sd_clk), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .running(running), .cur_fast(cur_fast), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=parked, 1=high, 2=low; el counts cycles spent in the phase.
  int          m_ph = 0;
  int          m_el = 0;
  int          m_w  = 1;
  logic        m_sd = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_fast = 1'b0;
  logic [1:0]  m_cq = 2'b00;
  logic [15:0] m_ec = 16'd0;

  task start_high();
    m_fast = m_cq[1];
    m_w    = m_fast ? FD : SD;
    m_el   = 0;
    m_ph   = 1;
    m_sd   = 1'b1;
    m_rise = 1'b1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0; m_el = 0; m_w = 1;
      m_sd = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_fast = 1'b0;
      m_cq = 2'b00; m_ec = 16'd0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_ph == 0) begin
        if (m_cq[0]) begin
          m_ec = EC ? 16'd1 : 16'd0;
          start_high();
        end
      end else begin
        m_el++;
        if (m_el == m_w) begin
          if (m_ph == 1) begin
            m_ph = 2; m_el = 0; m_sd = 1'b0; m_fall = 1'b1;
          end else if (m_cq[0]) begin
            m_ec = EC ? m_ec + 16'd1 : 16'd0;
            start_high();
          end else begin
            m_ph = 0;
          end
        end
      end
      m_cq = ctrl_in;
    end
  end

  always @(negedge clk) begin
    chk("sd_clk", {15'd0, sd_clk}, {15'd0, m_sd});
    chk("rise_stb", {15'd0, rise_stb}, {15'd0, m_rise});
    chk("fall_stb", {15'd0, fall_stb}, {15'd0, m_fall});
    chk("running", {15'd0, running}, {15'd0, (m_ph != 0)});
    chk("cur_fast", {15'd0, cur_fast}, {15'd0, m_fast});
    chk("edge_count", edge_count, m_ec);
  end

  task automatic wait_sd(input logic v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sd_clk !== v && n < 400);
    chk("wait_sd_reached", {15'd0, sd_clk}, {15'd0, v});
  endtask

  task automatic run_len(input int n0, output int n);
    logic v;
    v = sd_clk;
    n = n0;
    while (n < 400) begin
      @(negedge clk);
      if (sd_clk !== v) break;
      n++;
    end
  endtask

  int h, l, n, r, f;

  initial begin
    // Reset held with enable requested: everything stays low.
    ctrl_in = 2'b01;
    repeat (4) @(negedge clk);
    chk("rst_sd_clk", {15'd0, sd_clk}, 16'd0);
    chk("rst_running", {15'd0, running}, 16'd0);
    reset_n = 1'b1;
    wait_sd(1'b1, n);
    chk("first_rise_edge", n[15:0], 16'd2);
    chk("first_rise_stb", {15'd0, rise_stb}, 16'd1);
    run_len(1, h);
    chk("slow_high", h[15:0], 16'd63);
    chk("slow_fall_stb", {15'd0, fall_stb}, 16'd1);
    run_len(1, l);
    chk("slow_period", 16'(h + l), 16'd126);

    // Speed change requested in the first cycle of a slow high.
    ctrl_in = 2'b11;
    run_len(1, h);
    chk("chg_high", h[15:0], 16'd63);
    run_len(1, l);
    chk("chg_low", l[15:0], 16'd63);
    chk("chg_cur_fast", {15'd0, cur_fast}, 16'd1);
    run_len(1, h);
    chk("fast_high", h[15:0], 16'd1);
    run_len(1, l);
    chk("fast_low", l[15:0], 16'd1);
    r = 0; f = 0;
    repeat (20) begin
      @(negedge clk);
      r += int'(rise_stb);
      f += int'(fall_stb);
    end
    chk("fast_rises", r[15:0], 16'd10);
    chk("fast_falls", f[15:0], 16'd10);

    // Back to slow, then disable at cycle 10 of a slow high.
    ctrl_in = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rise_stb === 1'b1 && cur_fast === 1'b0) && n < 400);
    chk("slow_again", {15'd0, cur_fast}, 16'd0);
    repeat (9) @(negedge clk);
    ctrl_in = 2'b00;
    run_len(10, h);
    chk("dis_high", h[15:0], 16'd63);
    n = 0;
    while (running === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("dis_low_running", n[15:0], 16'd63);
    r = 0;
    repeat (200) begin
      @(negedge clk);
      r += int'(rise_stb);
    end
    chk("dis_no_rise", r[15:0], 16'd0);
    chk("dis_idle_running", {15'd0, running}, 16'd0);

    // Asynchronous reset in the middle of a high phase.
    ctrl_in = 2'b01;
    wait_sd(1'b1, n);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_sd_clk", {15'd0, sd_clk}, 16'd0);
    chk("async_running", {15'd0, running}, 16'd0);
    chk("async_strobes", {14'd0, rise_stb, fall_stb}, 16'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_sd(1'b1, n);
    chk("restart_rise_edge", n[15:0], 16'd2);
    chk("restart_edge_cnt", edge_count, EC ? 16'd1 : 16'd0);
    run_len(1, h);
    run_len(1, l);
    chk("second_edge_cnt", edge_count, EC ? 16'd2 : 16'd0);

    // Disable then re-enable: the edge counter restarts at 1.
    ctrl_in = 2'b00;
    n = 0;
    while (running === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("reen_idle", {15'd0, running}, 16'd0);
    ctrl_in = 2'b01;
    wait_sd(1'b1, n);
    chk("reen_edge_cnt", edge_count, EC ? 16'd1 : 16'd0);

    // Random control traffic, with occasional off-edge resets.
    for (int i = 0; i < 60; i++) begin
      ctrl_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) n = $urandom_range(1, 8);
      else n = $urandom_range(20, 250);
      repeat (n) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        #2 reset_n = 1'b0;
        #1 chk("rnd_async_sd_clk", {15'd0, sd_clk}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
